// File: rtl/demux_sequencer.sv
// demux_sequencer: hands one accepted bit at a time to a 4-way demux, holding it for HOLD_CYCLES cycles.
// Per-channel saturating delivery counters are built only when DEMUX_SEQUENCER_COUNT_EN is defined.
module demux_sequencer #(
    parameter int HOLD_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_data,
    input  logic [1:0]  in_dest,
    input  logic        auto_rr,
    input  logic        cnt_clr,
    output logic        dm_in,
    output logic [1:0]  dm_sel,
    output logic        dm_strobe,
    output logic [31:0] cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    localparam logic [3:0] HOLD_LAST = 4'(HOLD_CYCLES - 1);

    state_t     state_q;
    logic [3:0] hold_q;
    logic [1:0] ptr_q;
    logic       in_ready_q;
    logic       dm_in_q;
    logic [1:0] dm_sel_q;
    logic       dm_strobe_q;
    logic       xfer_s;
    logic [1:0] dest_s;

    // Accept decode and destination choice for the current cycle
    always_comb begin
        xfer_s = 1'b0;
        dest_s = in_dest;
        if ((state_q == IDLE) && in_valid) begin
            xfer_s = 1'b1;
        end else begin
            xfer_s = 1'b0;
        end
        if (auto_rr) begin
            dest_s = ptr_q;
        end else begin
            dest_s = in_dest;
        end
    end

    // Sequencer FSM; every demux-facing output is a register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= 4'd0;
            ptr_q       <= 2'd0;
            in_ready_q  <= 1'b1;
            dm_in_q     <= 1'b0;
            dm_sel_q    <= 2'd0;
            dm_strobe_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (xfer_s) begin
                        state_q     <= DRIVE;
                        hold_q      <= HOLD_LAST;
                        in_ready_q  <= 1'b0;
                        dm_in_q     <= in_data;
                        dm_sel_q    <= dest_s;
                        dm_strobe_q <= 1'b1;
                        if (auto_rr) begin
                            ptr_q <= ptr_q + 2'd1;
                        end
                    end
                end
                DRIVE: begin
                    if (hold_q == 4'd0) begin
                        state_q     <= GAP;
                        dm_in_q     <= 1'b0;
                        dm_strobe_q <= 1'b0;
                    end else begin
                        hold_q <= hold_q - 4'd1;
                    end
                end
                GAP: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                end
                default: begin
                    // Unreachable encoding: fall back to a quiet IDLE
                    state_q     <= IDLE;
                    in_ready_q  <= 1'b1;
                    dm_in_q     <= 1'b0;
                    dm_strobe_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign dm_in     = dm_in_q;
    assign dm_sel    = dm_sel_q;
    assign dm_strobe = dm_strobe_q;

`ifdef DEMUX_SEQUENCER_COUNT_EN
    logic [3:0][7:0] cnt_q;
    logic [3:0][7:0] cnt_d;

    // Clear beats a coincident transfer; counts stick at 255
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clr) begin
            cnt_d = 32'd0;
        end else if (xfer_s && (cnt_q[dest_s] != 8'hFF)) begin
            cnt_d[dest_s] = cnt_q[dest_s] + 8'd1;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Delivery counter register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;
`else
    logic unused_cnt_clr_s;
    assign unused_cnt_clr_s = cnt_clr;
    assign cnt              = 32'd0;
`endif

endmodule

// File: tb/tb_demux_sequencer.sv
// Scoreboard bench for demux_sequencer: stimulus pushes expected {sel,data}, a negedge monitor pops and checks.
module tb_demux_sequencer;

    localparam int HOLD = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic        in_data;
    logic [1:0]  in_dest;
    logic        auto_rr;
    logic        cnt_clr;
    logic        dm_in;
    logic [1:0]  dm_sel;
    logic        dm_strobe;
    logic [31:0] cnt;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_q[$];
    logic [7:0] exp_cnt[4];
    logic [1:0] ptr_m;

    always #5 clk = ~clk;

    demux_sequencer #(.HOLD_CYCLES(HOLD)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_dest(in_dest), .auto_rr(auto_rr), .cnt_clr(cnt_clr),
        .dm_in(dm_in), .dm_sel(dm_sel), .dm_strobe(dm_strobe), .cnt(cnt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] exp_cnt_vec();
`ifdef DEMUX_SEQUENCER_COUNT_EN
        return {exp_cnt[3], exp_cnt[2], exp_cnt[1], exp_cnt[0]};
`else
        return 32'd0;
`endif
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) exp_cnt[k] = 8'd0;
        ptr_m = 2'd0;
        exp_q.delete();
    endtask

    // Offer one bit, wait for acceptance, record the expected routing
    task automatic send(input logic d, input logic [1:0] dst, input logic ar);
        int n = 0;
        logic [1:0] eff;
        in_valid = 1'b1; in_data = d; in_dest = dst; auto_rr = ar;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL send_timeout: in_ready=%b after 50 cycles, expected 1", in_ready);
        end else begin
            eff = ar ? ptr_m : dst;
            exp_q.push_back({eff, d});
            if (ar) ptr_m = ptr_m + 2'd1;
            if (cnt_clr) begin
                for (int k = 0; k < 4; k++) exp_cnt[k] = 8'd0;
            end else if (exp_cnt[eff] != 8'd255) begin
                exp_cnt[eff] = exp_cnt[eff] + 8'd1;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || in_ready !== 1'b1 || dm_strobe !== 1'b0) && n < 100) begin
            @(posedge clk); #1; n++;
        end
        if (n >= 100) begin
            checks++; errors++;
            $display("FAIL drain_timeout: %0d transfers pending, expected 0", exp_q.size());
        end
    endtask

    logic       prev_strobe = 1'b0;
    logic       gap_seen    = 1'b0;
    int         run         = 0;
    logic [2:0] cur         = 3'd0;

    // Monitor: compares each strobe burst, the GAP cycle and the return to IDLE
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_strobe = 1'b0; gap_seen = 1'b0; run = 0;
        end else begin
            if (dm_strobe && !prev_strobe) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_strobe: sel=%0d data=%b with no pending transfer", dm_sel, dm_in);
                end else begin
                    cur = exp_q.pop_front();
                    check("route_sel", 32'(dm_sel), 32'(cur[2:1]));
                    check("route_data", 32'(dm_in), 32'(cur[0]));
                end
                check("drive_ready", 32'(in_ready), 32'd0);
                run = 1;
            end else if (dm_strobe) begin
                run++;
                check("sel_stable", 32'(dm_sel), 32'(cur[2:1]));
                check("data_stable", 32'(dm_in), 32'(cur[0]));
                check("drive_ready", 32'(in_ready), 32'd0);
            end else if (prev_strobe) begin
                check("hold_len", 32'(run), 32'(HOLD));
                check("gap_ready", 32'(in_ready), 32'd0);
                check("gap_sel", 32'(dm_sel), 32'(cur[2:1]));
                check("gap_data", 32'(dm_in), 32'd0);
                gap_seen = 1'b1;
            end else if (gap_seen) begin
                check("ready_after_gap", 32'(in_ready), 32'd1);
                check("idle_sel_hold", 32'(dm_sel), 32'(cur[2:1]));
                gap_seen = 1'b0;
            end
            prev_strobe = dm_strobe;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = 1'b0; in_dest = 2'd0;
        auto_rr = 1'b0; cnt_clr = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd1);
        check("rst_strobe", 32'(dm_strobe), 32'd0);
        check("rst_sel", 32'(dm_sel), 32'd0);
        check("rst_dm_in", 32'(dm_in), 32'd0);
        check("rst_cnt", cnt, 32'd0);

        // Manual route; first edge after release must already accept
        @(negedge clk); rst_n = 1'b1;
        send(1'b1, 2'd2, 1'b0);
        drain();
        check("manual_cnt", cnt, exp_cnt_vec());

        // Round-robin 0,1,2,3,0 then a manual bit must not move the pointer
        send(1'b1, 2'd3, 1'b1);
        send(1'b0, 2'd3, 1'b1);
        send(1'b1, 2'd0, 1'b1);
        send(1'b1, 2'd1, 1'b1);
        send(1'b0, 2'd2, 1'b1);
        send(1'b0, 2'd3, 1'b0);
        send(1'b1, 2'd0, 1'b1);
        drain();
        check("rr_cnt", cnt, exp_cnt_vec());

        // Busy: inputs wiggle while driving; only the later IDLE offer counts
        in_valid = 1'b1; in_data = 1'b1; in_dest = 2'd0; auto_rr = 1'b0;
        check("busy_ready_pre", 32'(in_ready), 32'd1);
        exp_q.push_back({2'd0, 1'b1});
        if (exp_cnt[0] != 8'd255) exp_cnt[0] = exp_cnt[0] + 8'd1;
        @(posedge clk); #1;
        for (int i = 0; i < HOLD + 1; i++) begin
            in_dest = ~in_dest; in_data = ~in_data;
            @(posedge clk); #1;
        end
        check("busy_ready_idle", 32'(in_ready), 32'd1);
        in_dest = 2'd3; in_data = 1'b0;
        exp_q.push_back({2'd3, 1'b0});
        if (exp_cnt[3] != 8'd255) exp_cnt[3] = exp_cnt[3] + 8'd1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        drain();
        check("busy_cnt", cnt, exp_cnt_vec());

        // Asynchronous reset in the middle of DRIVE
        send(1'b1, 2'd2, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_strobe", 32'(dm_strobe), 32'd0);
        check("async_rst_sel", 32'(dm_sel), 32'd0);
        check("async_rst_ready", 32'(in_ready), 32'd1);
        check("async_rst_dm_in", 32'(dm_in), 32'd0);
        model_reset();
        check("async_rst_cnt", cnt, exp_cnt_vec());
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_redrive_ready", 32'(in_ready), 32'd1);
        send(1'b1, 2'd1, 1'b1);
        drain();
        check("post_rst_ptr_cnt", cnt, exp_cnt_vec());

        // Saturation on channel 1
        for (int i = 0; i < 260; i++) send(1'(i), 2'd1, 1'b0);
        drain();
        check("sat_cnt", cnt, exp_cnt_vec());

        // Clear coincident with a transfer, then counting resumes
        cnt_clr = 1'b1;
        send(1'b1, 2'd0, 1'b0);
        cnt_clr = 1'b0;
        drain();
        check("clr_cnt", cnt, exp_cnt_vec());
        send(1'b1, 2'd3, 1'b0);
        drain();
        check("after_clr_cnt", cnt, exp_cnt_vec());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
